keycode_packer: RTL and testbench
=================================

Name: keycode_packer

Overview:
- Board-button keyboard emulator that produces the same 32-bit, four-slot USB HID keycode word the game logic already decodes.
- Four raw pushbutton levels (A, S, K, L) are synchronised, debounced, and tracked in press order in four slots.
- Each change to the held-key set is published as a new keycode word over a valid/ready handshake.
- Sits in place of the USB keyboard path, feeding the keycode register, for cabinet play and for bench stimulus.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised input must differ from its debounced level before the new level is accepted. Legal range ≥1; 10 ms at 50 MHz.
- CODE_A, 8'h04, HID usage code for A.
- CODE_S, 8'h16, HID usage code for S.
- CODE_K, 8'h0E, HID usage code for K.
- CODE_L, 8'h0F, HID usage code for L.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- a_raw, s_raw, k_raw, l_raw  in  1 each  asynchronous button levels, 1 = pressed.
- keycode  out  32  published word: slot0 = [7:0] (oldest held) … slot3 = [31:24] (newest); 8'h00 = empty slot.
- report_valid  out  1  published word available.
- report_ready  in  1  consumer accepts word.
- held_mask  out  4  committed held set {l,k,s,a} (bit0 = a).

Behaviour:
- Reset (async assert, sync release): keycode=0, report_valid=0, held_mask=0, all slots 0, sync flops 0, debounced levels 0, counters 0, FSM=IDLE.
- Per-key sync: two-flop synchroniser on each raw input.
- Per-key debounce:
  - Counter clears whenever synced == debounced.
  - When synced != debounced, counter increments.
  - On the cycle the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, debounced <= synced and counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change debounced.
- Pending event: a key is pending when its debounced level != its held_mask bit.
- FSM state IDLE:
  - If any event is pending, go to APPLY.
  - Otherwise stay in IDLE.
- FSM state APPLY: applies exactly one event per cycle.
  - Priority: releases before presses; within each group, order a, s, k, l.
  - Press: write the key's code into the lowest empty slot; set its held_mask bit.
  - Release: remove the key's slot and shift all higher slots down by one (compaction preserves press order); zero slot3; clear its held_mask bit.
  - If no further event is pending after this one, load keycode from the updated slots on the same edge and go to PUBLISH. Otherwise stay in APPLY.
- FSM state PUBLISH:
  - report_valid=1; keycode held stable.
  - When report_ready=1, go to IDLE (report_valid=0 next cycle).
  - Debounce keeps running during PUBLISH; new events stay pending and are applied after the handshake. Updates are never dropped or merged into an in-flight word.
- Slot capacity equals the key count, so overflow is impossible.
  - Invariant: no duplicate codes.
  - Invariant: occupied slots are contiguous from slot0.
  - Invariant: popcount(held_mask) == number of occupied slots.
- Latency, stable input change to report_valid=1 (single event, FSM idle): 2 (sync) + DEBOUNCE_CYCLES + 2 cycles.
- Press then release within one APPLY burst: both are applied and only the final set is published. A press/release pair that is shorter than the debounce window produces no event at all.
- report_ready while report_valid=0 is ignored.
- Reset asserted mid-handshake: report_valid drops immediately and the held set clears. After release, currently-pressed buttons re-debounce and publish as fresh presses.

Test Plan (DEBOUNCE_CYCLES=4, report_ready tied 1 unless stated):
1. Reset, then press a_raw and hold → after 8 cycles report_valid pulses 1 cycle with keycode=32'h0000_0004, held_mask=4'b0001.
2. Hold a; press k, then s, one at a time → successive words 32'h0000_0E04, then 32'h0016_0E04.
3. From {a,k,s}, release k → keycode=32'h0000_1604 (compacted), held_mask=4'b0011.
4. Glitch l_raw high for 3 cycles → no report_valid, held_mask unchanged. Glitch for 6 cycles → press word, then release word.
5. report_ready=0; press a, then press l while valid is held → keycode stays 32'h0000_0004 until ready. After the ready pulse, a second word 32'h0000_0F04 appears.
6. Press all four in one cycle → APPLY runs 4 cycles, one word 32'h0F0E_1604. Assert Reset_n=0 while valid → outputs zero asynchronously; after release with buttons still held, the same word is republished.

Source files
------------

// File: rtl/keycode_packer.sv
//------------------------------------------------------------------------------
// keycode_packer: four-button HID keycode word generator, press-ordered slots.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keycode_packer #(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter logic [7:0] CODE_A          = 8'h04,
   parameter logic [7:0] CODE_S          = 8'h16,
   parameter logic [7:0] CODE_K          = 8'h0E,
   parameter logic [7:0] CODE_L          = 8'h0F
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        a_raw,
   input  logic        s_raw,
   input  logic        k_raw,
   input  logic        l_raw,
   output logic [31:0] keycode,
   output logic        report_valid,
   input  logic        report_ready,
   output logic [3:0]  held_mask
);

   localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   state_t          state;
   logic [3:0]      raw;
   logic [3:0]      sync_meta;
   logic [3:0]      sync_q;
   logic [3:0]      deb;
   logic [3:0][7:0] slots;
   logic [7:0]      key_code [4];

   assign raw         = {l_raw, k_raw, s_raw, a_raw};
   assign key_code[0] = CODE_A;
   assign key_code[1] = CODE_S;
   assign key_code[2] = CODE_K;
   assign key_code[3] = CODE_L;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= raw;
         sync_q    <= sync_meta;
      end
   end

   generate
      for (genvar g = 0; g < 4; g++) begin : g_debounce
         logic [CNT_W-1:0] cnt;

         always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
               cnt    <= '0;
               deb[g] <= 1'b0;
            end else if (sync_q[g] == deb[g]) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               deb[g] <= sync_q[g];
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   endgenerate

   logic [3:0]      pending;
   logic [3:0]      rel_set;
   logic [3:0]      sel_vec;
   logic [3:0]      rest;
   logic [1:0]      sel;
   logic [1:0]      pos;
   logic            any_pending;
   logic [3:0][7:0] nslots;
   logic [3:0]      nmask;

   // Pick one event (releases first, lowest key index first) and form the updated slots.
   always_comb begin
      pending     = deb ^ held_mask;
      rel_set     = pending & held_mask;
      sel_vec     = (rel_set != 4'b0) ? rel_set : pending;
      any_pending = (pending != 4'b0);
      sel         = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (sel_vec[i]) sel = 2'(i);
      end
      rest   = pending & ~(4'b0001 << sel);
      nslots = slots;
      nmask  = held_mask;
      pos    = 2'd3;
      if (any_pending) begin
         nmask = held_mask ^ (4'b0001 << sel);
         if (rel_set != 4'b0) begin
            for (int i = 3; i >= 0; i--) begin
               if (slots[i] == key_code[sel]) pos = 2'(i);
            end
            for (int i = 0; i < 3; i++) begin
               if (2'(i) >= pos) nslots[i] = slots[i+1];
            end
            nslots[3] = 8'h00;
         end else begin
            for (int i = 3; i >= 0; i--) begin
               if (slots[i] == 8'h00) pos = 2'(i);
            end
            nslots[pos] = key_code[sel];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         slots        <= '0;
         held_mask    <= '0;
         keycode      <= '0;
         report_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_pending) state <= APPLY;
            end
            APPLY: begin
               slots     <= nslots;
               held_mask <= nmask;
               if (rest == 4'b0) begin
                  keycode      <= nslots;
                  report_valid <= 1'b1;
                  state        <= PUBLISH;
               end
            end
            PUBLISH: begin
               if (report_ready) begin
                  report_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               report_valid <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_keycode_packer.sv
//------------------------------------------------------------------------------
// tb_keycode_packer: directed vector bench for keycode_packer (DEBOUNCE_CYCLES=4).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_keycode_packer;

   logic        Clk          = 1'b0;
   logic        Reset_n      = 1'b0;
   logic        a_raw        = 1'b0;
   logic        s_raw        = 1'b0;
   logic        k_raw        = 1'b0;
   logic        l_raw        = 1'b0;
   logic        report_ready = 1'b1;
   logic [31:0] keycode;
   logic        report_valid;
   logic [3:0]  held_mask;

   int checks   = 0;
   int failures = 0;

   keycode_packer #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .a_raw       (a_raw),
      .s_raw       (s_raw),
      .k_raw       (k_raw),
      .l_raw       (l_raw),
      .keycode     (keycode),
      .report_valid(report_valid),
      .report_ready(report_ready),
      .held_mask   (held_mask)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0]  keys;      // {l,k,s,a}
      logic [31:0] exp_code;
      logic [3:0]  exp_mask;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_keys(input logic [3:0] k);
      {l_raw, k_raw, s_raw, a_raw} = k;
   endtask

   task automatic wait_valid(input string name, output int cycles);
      cycles = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge Clk);
         if (report_valid) begin
            cycles = n;
            break;
         end
      end
      if (cycles < 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: report_valid low for 40 cycles, expected high", name);
      end
   endtask

   initial begin
      int  lat;
      logic seen;
      logic stable;

      vecs[0] = '{4'b0001, 32'h0000_0004, 4'b0001};
      vecs[1] = '{4'b0101, 32'h0000_0E04, 4'b0101};
      vecs[2] = '{4'b0111, 32'h0016_0E04, 4'b0111};
      vecs[3] = '{4'b0011, 32'h0000_1604, 4'b0011};
      vecs[4] = '{4'b0010, 32'h0000_0016, 4'b0010};
      vecs[5] = '{4'b0000, 32'h0000_0000, 4'b0000};
      vecs[6] = '{4'b1000, 32'h0000_000F, 4'b1000};
      vecs[7] = '{4'b1001, 32'h0000_040F, 4'b1001};
      vecs[8] = '{4'b0000, 32'h0000_0000, 4'b0000};

      repeat (3) @(negedge Clk);
      check("reset_keycode", keycode, 32'h0);
      check("reset_valid", {31'b0, report_valid}, 32'h0);
      check("reset_mask", {28'b0, held_mask}, 32'h0);
      Reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         drive_keys(vecs[i].keys);
         wait_valid($sformatf("vec%0d", i), lat);
         check($sformatf("vec%0d_keycode", i), keycode, vecs[i].exp_code);
         check($sformatf("vec%0d_mask", i), {28'b0, held_mask}, {28'b0, vecs[i].exp_mask});
         if (i == 0) check("first_latency", 32'(lat), 32'd8);
         @(negedge Clk);
         check($sformatf("vec%0d_pulse_len", i), {31'b0, report_valid}, 32'h0);
      end

      // Short glitch must be absorbed by the debouncer.
      drive_keys(4'b1000);
      repeat (3) @(negedge Clk);
      drive_keys(4'b0000);
      seen = 1'b0;
      repeat (20) begin
         @(negedge Clk);
         if (report_valid) seen = 1'b1;
      end
      check("glitch3_no_valid", {31'b0, seen}, 32'h0);
      check("glitch3_mask", {28'b0, held_mask}, 32'h0);

      drive_keys(4'b1000);
      repeat (6) @(negedge Clk);
      drive_keys(4'b0000);
      wait_valid("glitch6_press", lat);
      check("glitch6_press_code", keycode, 32'h0000_000F);
      check("glitch6_press_mask", {28'b0, held_mask}, 32'h8);
      @(negedge Clk);
      wait_valid("glitch6_release", lat);
      check("glitch6_release_code", keycode, 32'h0);
      check("glitch6_release_mask", {28'b0, held_mask}, 32'h0);
      @(negedge Clk);

      // Back-pressure: word must hold while a newer event waits.
      report_ready = 1'b0;
      drive_keys(4'b0001);
      wait_valid("hold_first", lat);
      check("hold_first_code", keycode, 32'h0000_0004);
      drive_keys(4'b1001);
      stable = 1'b1;
      repeat (20) begin
         @(negedge Clk);
         if (!report_valid || keycode !== 32'h0000_0004) stable = 1'b0;
      end
      check("hold_stable", {31'b0, stable}, 32'h1);
      report_ready = 1'b1;
      @(negedge Clk);
      report_ready = 1'b0;
      @(negedge Clk);
      check("hold_valid_drop", {31'b0, report_valid}, 32'h0);
      wait_valid("hold_second", lat);
      check("hold_second_code", keycode, 32'h0000_0F04);
      check("hold_second_mask", {28'b0, held_mask}, 32'h9);
      report_ready = 1'b1;
      @(negedge Clk);
      check("hold_second_done", {31'b0, report_valid}, 32'h0);
      drive_keys(4'b0000);
      wait_valid("hold_release", lat);
      check("hold_release_code", keycode, 32'h0);
      @(negedge Clk);

      // All four at once, then reset while the word is outstanding.
      report_ready = 1'b0;
      drive_keys(4'b1111);
      wait_valid("all4", lat);
      check("all4_latency", 32'(lat), 32'd11);
      check("all4_code", keycode, 32'h0F0E_1604);
      check("all4_mask", {28'b0, held_mask}, 32'hF);
      Reset_n = 1'b0;
      #1;
      check("rst_mid_valid", {31'b0, report_valid}, 32'h0);
      check("rst_mid_code", keycode, 32'h0);
      check("rst_mid_mask", {28'b0, held_mask}, 32'h0);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      wait_valid("republish", lat);
      check("republish_latency", 32'(lat), 32'd11);
      check("republish_code", keycode, 32'h0F0E_1604);
      check("republish_mask", {28'b0, held_mask}, 32'hF);
      report_ready = 1'b1;
      @(negedge Clk);
      check("republish_done", {31'b0, report_valid}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
